// File: rtl/icache_pkg.sv
// Shared definitions for the direct-mapped instruction cache: state encodings,
// default geometry and boolean constants.
package icache_pkg;

    localparam int unsigned DEFAULT_INDEX_BITS = 6;
    localparam int unsigned WORD_W             = 32;

    localparam logic True  = 1'b1;
    localparam logic False = 1'b0;

    typedef enum logic {
        ICACHE_IDLE = 1'b0,
        ICACHE_FILL = 1'b1
    } icache_state_e;

endpackage

// File: rtl/icache_array.sv
// Tag/data/valid storage for the instruction cache: combinational read port,
// synchronous write port, valid bits cleared asynchronously by rst.
module icache_array
    import icache_pkg::*;
#(
    parameter int unsigned INDEX_BITS = DEFAULT_INDEX_BITS,
    parameter int unsigned TAG_BITS   = 30 - INDEX_BITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INDEX_BITS-1:0] rd_idx_i,
    output logic                  rd_valid_o,
    output logic [TAG_BITS-1:0]   rd_tag_o,
    output logic [WORD_W-1:0]     rd_data_o,
    input  logic                  we_i,
    input  logic [INDEX_BITS-1:0] wr_idx_i,
    input  logic [TAG_BITS-1:0]   wr_tag_i,
    input  logic [WORD_W-1:0]     wr_data_i
);

    localparam int unsigned LINES = 1 << INDEX_BITS;

    logic [TAG_BITS-1:0] tag_q  [LINES];
    logic [WORD_W-1:0]   data_q [LINES];
    logic [LINES-1:0]    valid_q;

    // Tag and data carry no reset; only the valid bits need a known state.
    always_ff @(posedge clk) begin
        if (we_i) begin
            tag_q[wr_idx_i]  <= wr_tag_i;
            data_q[wr_idx_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else if (we_i) begin
            valid_q[wr_idx_i] <= True;
        end
    end

    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_data_o  = data_q[rd_idx_i];

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache with single-word lines.
// Optional hit/miss counters when ICACHE_STATS_EN is defined.
module icache
    import icache_pkg::*;
#(
    parameter int unsigned INDEX_BITS = DEFAULT_INDEX_BITS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              clr,
    input  logic              if_req,
    input  logic [WORD_W-1:0] if_pc,
    output logic              inst_valid,
    output logic [WORD_W-1:0] inst_out,
    output logic              ic_flag,
    output logic [WORD_W-1:0] addr_target,
    input  logic [WORD_W-1:0] ic_val_out,
    input  logic              ic_isok
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt
`endif
);

    localparam int unsigned TAG_BITS = 30 - INDEX_BITS;

    icache_state_e     state_q;
    logic              inst_valid_q;
    logic [WORD_W-1:0] inst_out_q;
    logic              ic_flag_q;
    logic [WORD_W-1:0] addr_target_q;
    logic              squash_q;

    logic                  rd_valid;
    logic [TAG_BITS-1:0]   rd_tag;
    logic [WORD_W-1:0]     rd_data;
    logic                  accept_c;
    logic                  hit_c;
    logic                  fill_we_c;

    icache_array #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_BITS   (TAG_BITS)
    ) u_array (
        .clk        (clk),
        .rst        (rst),
        .rd_idx_i   (if_pc[INDEX_BITS+1:2]),
        .rd_valid_o (rd_valid),
        .rd_tag_o   (rd_tag),
        .rd_data_o  (rd_data),
        .we_i       (fill_we_c),
        .wr_idx_i   (addr_target_q[INDEX_BITS+1:2]),
        .wr_tag_i   (addr_target_q[WORD_W-1:INDEX_BITS+2]),
        .wr_data_i  (ic_val_out)
    );

    // A new fetch is taken only after the previous response pulse has retired.
    assign accept_c  = (state_q == ICACHE_IDLE) && rdy && if_req && !inst_valid_q;
    assign hit_c     = rd_valid && (rd_tag == if_pc[WORD_W-1:INDEX_BITS+2]);
    assign fill_we_c = (state_q == ICACHE_FILL) && rdy && ic_isok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ICACHE_IDLE;
            inst_valid_q  <= False;
            inst_out_q    <= '0;
            ic_flag_q     <= False;
            addr_target_q <= '0;
            squash_q      <= False;
        end else if (rdy) begin
            inst_valid_q <= False;
            case (state_q)
                ICACHE_IDLE: begin
                    if (accept_c) begin
                        if (hit_c) begin
                            inst_out_q   <= rd_data;
                            inst_valid_q <= !clr;
                        end else begin
                            addr_target_q <= if_pc & ~WORD_W'(3);
                            ic_flag_q     <= True;
                            squash_q      <= False;
                            state_q       <= ICACHE_FILL;
                        end
                    end
                end
                ICACHE_FILL: begin
                    // A flush only marks the response dead; the controller's
                    // byte sequence must still run to completion.
                    if (clr) begin
                        squash_q <= True;
                    end
                    if (ic_isok) begin
                        ic_flag_q    <= False;
                        inst_out_q   <= ic_val_out;
                        inst_valid_q <= !(squash_q || clr);
                        state_q      <= ICACHE_IDLE;
                    end
                end
                default: begin
                    state_q <= ICACHE_IDLE;
                end
            endcase
        end
    end

    assign inst_valid  = inst_valid_q;
    assign inst_out    = inst_out_q;
    assign ic_flag     = ic_flag_q;
    assign addr_target = addr_target_q;

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (accept_c) begin
            if (hit_c) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end else begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: doc/icache.md
# icache

Direct-mapped, read-only instruction cache between the instruction fetcher and the memory controller. Services one fetch at a time: hits return in one cycle, misses issue a whole-word fill through the controller's 4-byte sequential read port and return the word when the fill completes. A flush input squashes an in-flight response without breaking the controller's byte sequence.

## Interface
Parameters:
- INDEX_BITS, 6, line-index width; 2^INDEX_BITS lines of one 32-bit word each
- TAG_BITS, 30-INDEX_BITS, derived; tag = addr[31:INDEX_BITS+2]

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- rdy  in  1  global enable; low freezes all state and outputs
- clr  in  1  flush/mispredict: squash pending response
- if_req  in  1  fetcher requests instruction at if_pc (level)
- if_pc  in  32  fetch address, word aligned, stable while if_req high
- inst_valid  out  1  one-cycle pulse, inst_out valid
- inst_out  out  32  fetched instruction
- ic_flag  out  1  fill request to memory controller
- addr_target  out  32  fill word address, {tag,index,2'b00}
- ic_val_out  in  32  assembled word from controller, valid when ic_isok=1
- ic_isok  in  1  controller fill-done strobe (one cycle)

## Operation
- Storage: tag array, data array (no reset), valid bit per line (async cleared by rst).
- States: IDLE, FILL.
- Accept: in IDLE, rdy=1, if_req=1, inst_valid=0 -> lookup index=if_pc[INDEX_BITS+1:2].
- Hit (valid & tag match): inst_out<=data, inst_valid<=1, stay IDLE.
- Miss: latch addr_target=if_pc word address, ic_flag<=1, squash<=0, go FILL.
- FILL: hold ic_flag and addr_target constant; on edge with ic_isok=1: write tag/data, set valid, ic_flag<=0, go IDLE, inst_out<=ic_val_out, inst_valid<=!(squash|clr).
- clr in IDLE: cancels a hit pulse being produced that edge (inst_valid<=0); no state change.
- clr in FILL: set squash; fill runs to completion (ic_flag must not drop mid-sequence), line still installed, no inst_valid.
- clr and ic_isok same edge: line installed, inst_valid=0.
- rst mid-FILL: return to IDLE, ic_flag=0 immediately; controller's own reset realigns its byte counter.
- Reset values: inst_valid=0, inst_out=0, ic_flag=0, addr_target=0, state IDLE, all valid=0.

## Timing
- Hit: request sampled edge N -> inst_valid high cycle N+1 for exactly one cycle.
- Next request accepted earliest edge N+2 (inst_valid gate); hit throughput one per 2 cycles.
- Miss: ic_flag rises cycle N+1; controller supplies ic_isok after its 4-byte read (~5 cycles); inst_valid the cycle after the ic_isok cycle.
- ic_flag deasserts at the same edge that samples ic_isok=1, so the controller never starts a second read.
- rdy=0: no state/output change; a pending ic_isok is not consumed (controller also stalls).
- Index wrap: addresses differing only in tag evict each other; no replacement policy beyond overwrite.

## Configuration
- ICACHE_STATS_EN defined: adds outputs hit_cnt[31:0], miss_cnt[31:0]; increment once per accepted hit/miss (squashed misses counted), reset to 0, wrap modulo 2^32, frozen when rdy=0.
- Undefined: ports and counters absent; behaviour otherwise identical.

## Structure
- Shared defines header: ICACHE_IDLE/ICACHE_FILL state encodings, default INDEX_BITS, True/False constants already there.
- One sub-module natural: icache_array (tag+data+valid storage, combinational read, synchronous write, async valid clear).

## Test plan
- Cold miss: if_pc=0x0000_1000 -> ic_flag=1, addr_target=0x0000_1000; controller returns 0x00A00093 -> inst_valid one cycle, inst_out=0x00A00093, ic_flag=0.
- Re-fetch 0x0000_1000 -> inst_valid cycle after accept, no ic_flag.
- Conflict: fetch 0x0000_1000 then 0x0000_1100 (INDEX_BITS=6, same index) -> both miss; refetch 0x1000 misses again.
- clr during FILL of 0x2000 -> ic_flag held until ic_isok, no inst_valid; subsequent 0x2000 fetch hits.
- rdy=0 for 3 cycles with ic_isok held high -> no change; on rdy=1 fill completes once, single inst_valid.
- rst asserted mid-FILL -> ic_flag, inst_valid 0 asynchronously; previously filled 0x1000 now misses; with ICACHE_STATS_EN, counters read 0.
